// File: rtl/alu_arbiter_pkg.sv
// Purpose: shared word width, ALUop encodings, requester ids and slot state
//          for the ALU arbiter and its ALU.
`ifndef ALU_ARBITER_WORD
`define ALU_ARBITER_WORD
`define WORD 16
`endif

package alu_arbiter_pkg;

    localparam int unsigned WORD_W  = `WORD;
    localparam int unsigned ALUOP_W = 5;

    typedef enum logic [ALUOP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SHL   = 5'd5,
        OP_SHR   = 5'd6,
        OP_PASSX = 5'd7
    } alu_op_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Result slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: purely combinational ALU shared by the arbiter's requesters.
// Ports:
//   op - ALUop (OP_* encodings)
//   x  - operand X
//   y  - operand Y (low bits give the shift amount for shifts)
//   z  - WIDTH-bit result; carries and overflow are discarded
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned OPW   = ALUOP_W
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = y[SHW-1:0];

    // Operation select; unknown opcodes yield zero.
    always_comb begin
        z = '0;
        case (op)
            OPW'(OP_ADD):   z = x + y;
            OPW'(OP_SUB):   z = x - y;
            OPW'(OP_AND):   z = x & y;
            OPW'(OP_OR):    z = x | y;
            OPW'(OP_XOR):   z = x ^ y;
            OPW'(OP_SHL):   z = x << shamt;
            OPW'(OP_SHR):   z = x >> shamt;
            OPW'(OP_PASSX): z = x;
            default:        z = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbitration of two valid/ready requesters onto one
//          shared ALU, with a one-entry tagged result register.
// Ports:
//   clk, reset                       - clock, async active-high reset
//   reqN_valid/ready/op/x/y (N=0,1)  - requester handshakes and operands;
//                                      readies are combinational
//   res_valid/res_ready              - result handshake
//   res_id                           - requester that owns res_z
//   res_z                            - registered ALU result
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned OPW   = ALUOP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_z
);

    slot_e            slot_q, slot_d;
    logic             res_id_q, res_id_d;
    logic [WIDTH-1:0] res_z_q, res_z_d;
    logic             last_grant_q, last_grant_d;

    logic             gnt_any;
    logic             gnt_id;
    logic             can_accept;
    logic             accept;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_z;

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .op (alu_op),
        .x  (alu_x),
        .y  (alu_y),
        .z  (alu_z)
    );

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= SLOT_EMPTY;
            res_id_q     <= REQ0;
            res_z_q      <= '0;
            last_grant_q <= REQ1;
        end else begin
            slot_q       <= slot_d;
            res_id_q     <= res_id_d;
            res_z_q      <= res_z_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Grant, handshake and next-state logic.
    always_comb begin
        slot_d       = slot_q;
        res_id_d     = res_id_q;
        res_z_d      = res_z_q;
        last_grant_d = last_grant_q;

        gnt_any = req0_valid | req1_valid;
        // On contention the requester that did not win last time goes next.
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req1_valid ? REQ1 : REQ0;
        end

        can_accept = (slot_q == SLOT_EMPTY) || res_ready;
        req0_ready = !reset && gnt_any && can_accept && (gnt_id == REQ0);
        req1_ready = !reset && gnt_any && can_accept && (gnt_id == REQ1);
        accept     = req0_ready | req1_ready;

        // Requester 0 drives the ALU whenever requester 1 is not granted.
        if (gnt_any && (gnt_id == REQ1)) begin
            alu_op = req1_op;
            alu_x  = req1_x;
            alu_y  = req1_y;
        end else begin
            alu_op = req0_op;
            alu_x  = req0_x;
            alu_y  = req0_y;
        end

        case (slot_q)
            SLOT_EMPTY: begin
                if (accept) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!accept && res_ready) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase

        if (accept) begin
            res_z_d      = alu_z;
            res_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end
    end

    assign res_valid = (slot_q == SLOT_FULL);
    assign res_id    = res_id_q;
    assign res_z     = res_z_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` between two independent requesters (e.g. the execute stage and a secondary unit) using valid/ready handshakes.
- Round-robin grant; one operation accepted per cycle.
- The ALU result is captured in an output register, tagged with the requester id, and held under output backpressure.
- Sits between the requesters and the `alu` instance, which it owns internally.

Parameters:
- WIDTH, 16, data word width; must equal the shared `WORD width.
- OPW, 5, ALUop width; matches the `alu` op port.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OPW  requester 0 ALUop
- req0_x  in  WIDTH  requester 0 operand X
- req0_y  in  WIDTH  requester 0 operand Y
- req1_valid / req1_ready / req1_op / req1_x / req1_y  same as requester 0, for requester 1
- res_valid  out  1  result register holds an undelivered result
- res_ready  in  1  consumer takes the result this cycle
- res_id  out  1  requester that owns the result (0 or 1)
- res_z  out  WIDTH  ALU result

Behaviour:
- Reset (async, immediate):
  - res_valid=0, res_id=0, res_z=0.
  - Internal last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are 0 while reset is high.
- Slot state, two states:
  - EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = EMPTY | (FULL & res_ready).
- Grant (combinational, same cycle):
  - Only one valid request: it is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
  - reqN_ready = granted(N) & can_accept. At most one ready is high per cycle; a ready never rises without its valid.
- Accept (handshake reqN_valid & reqN_ready at the clock edge):
  - The granted op/x/y drive the `alu` inputs combinationally.
  - The `alu` output is registered into res_z, res_id=N, res_valid=1, last_grant=N.
  - Latency: result visible the cycle after accept (1 cycle).
- The `alu` inputs are driven from the granted requester; when nothing is granted they are driven from requester 0 (no functional effect).
- Delivery:
  - res_valid & res_ready with no new accept -> EMPTY next cycle.
  - With a simultaneous accept -> stays FULL with the new result. This gives back-to-back throughput of 1 op per cycle.
- Backpressure: while FULL & !res_ready:
  - res_z, res_id and res_valid hold stable.
  - Both readies are 0 and last_grant is unchanged.
- Requesters must hold op/x/y stable while valid & !ready. The arbiter does not latch an ungranted request.
- Fairness: with both valid continuously and res_ready=1, grants alternate 0,1,0,1...
- Width rule: res_z is the `alu` WIDTH-bit output unmodified. Carries and overflow are discarded per the `alu` definition.
- Reset mid-operation: an in-flight or undelivered result is dropped (res_valid=0), and the pointer returns to favour requester 0.

Decomposition:
- Shared package/defines: the `WORD macro (WIDTH), the ALUop width constant, ALUop encodings (OP_ADD, OP_SUB, OP_AND, ...), and requester id constants REQ0=0, REQ1=1.
- One sub-module: the existing `alu`, instantiated once inside alu_arbiter. Grant logic and the result register stay flat in alu_arbiter.

Test Plan:
- Reset then idle, all valids 0:
  - res_valid=0, both readies 0.
  - Assert reset mid-cycle with res_valid=1 -> res_valid drops to 0 immediately, before the next clk edge.
- Single request: req0 OP_ADD x=0x0003 y=0x0004, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_id=0, res_z=0x0007.
- Contention from reset: both valid, req0 OP_ADD 0x0001+0x0001, req1 OP_ADD 0x0010+0x0020, res_ready=1:
  - Cycle 1: req0 granted.
  - Cycle 2: req1 granted; results in order 0x0002 (id 0), then 0x0030 (id 1).
  - Continued contention keeps alternating.
- Backpressure: result 0x0007 held with res_ready=0 for 3 cycles while req1 is valid:
  - res_z/res_id remain stable and req1_ready=0 throughout.
  - Raising res_ready -> req1_ready=1 that cycle; new result appears next cycle with no bubble.
- Streaming: req1 only, 4 consecutive OP_ADD ops with res_ready=1 -> 4 results on 4 consecutive cycles, all res_id=1, values matching the `alu` model.
- Wrap/width: OP_ADD x=0xFFFF y=0x0001 -> res_z=0x0000, no extra output bits.
